// File: rtl/switch_led_ctrl.sv
// Switch-to-LED controller: 2-flop sync and per-bit debounce on N_SW switches,
// driving 2*N_SW registered LEDs in mirror, direct, blink-mirror or chase mode.
module switch_led_ctrl #(
  parameter int unsigned N_SW            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TICK_DIV        = 25000000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N_SW-1:0]     SlideSwitch,
  input  logic [1:0]          Mode,
  output logic [2*N_SW-1:0]   LEDOut
);

  localparam int unsigned N_LED = 2 * N_SW;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  localparam logic [1:0] MODE_MIRROR = 2'd0;
  localparam logic [1:0] MODE_DIRECT = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_CHASE  = 2'd3;

  logic [N_SW-1:0]  sync_d;
  logic [N_SW-1:0]  sync_q;
  logic [N_SW-1:0]  db;
  logic [CNT_W-1:0] cnt [N_SW];
  logic [PRE_W-1:0] presc;
  logic             phase;
  logic [N_LED-1:0] pos;
  logic [1:0]       mode_q;

  logic             tick_c;
  logic             entry_blink_c;
  logic             entry_chase_c;
  logic [N_LED-1:0] mir_c;
  logic [N_LED-1:0] pos_one_c;
  logic [N_LED-1:0] led_next_c;

  assign tick_c        = (presc == PRE_W'(TICK_DIV - 1));
  assign entry_blink_c = (Mode == MODE_BLINK) && (mode_q != MODE_BLINK);
  assign entry_chase_c = (Mode == MODE_CHASE) && (mode_q != MODE_CHASE);
  assign pos_one_c     = N_LED'(1);

  // Synchroniser and independent per-bit debounce counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_d <= '0;
      sync_q <= '0;
      db     <= '0;
      for (int i = 0; i < int'(N_SW); i++) cnt[i] <= '0;
    end else begin
      sync_d <= SlideSwitch;
      sync_q <= sync_d;
      for (int i = 0; i < int'(N_SW); i++) begin
        if (sync_q[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db[i]  <= sync_q[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Free-running prescaler; only reset clears it
  always_ff @(posedge Clk) begin
    if (Reset) presc <= '0;
    else if (tick_c) presc <= '0;
    else presc <= presc + PRE_W'(1);
  end

  // Blink phase and chase position; each holds while its mode is inactive
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_q <= MODE_MIRROR;
      phase  <= 1'b1;
      pos    <= pos_one_c;
    end else begin
      mode_q <= Mode;
      if (entry_blink_c) phase <= 1'b1;
      else if (Mode == MODE_BLINK && tick_c) phase <= ~phase;
      if (entry_chase_c) pos <= pos_one_c;
      else if (Mode == MODE_CHASE && tick_c) begin
        if (db[0]) pos <= {pos[0], pos[N_LED-1:1]};
        else       pos <= {pos[N_LED-2:0], pos[N_LED-1]};
      end
    end
  end

  always_comb begin
    mir_c = '0;
    for (int i = 0; i < int'(N_SW); i++) begin
      mir_c[i]             = db[i];
      mir_c[N_LED - 1 - i] = db[i];
    end
  end

  // Entry cycle shows the freshly re-initialised phase/position immediately
  always_comb begin
    led_next_c = '0;
    case (Mode)
      MODE_MIRROR: led_next_c = mir_c;
      MODE_DIRECT: led_next_c = {{N_SW{1'b0}}, db};
      MODE_BLINK:  led_next_c = (entry_blink_c || phase) ? mir_c : '0;
      MODE_CHASE:  led_next_c = entry_chase_c ? pos_one_c : pos;
      default:     led_next_c = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) LEDOut <= '0;
    else       LEDOut <= led_next_c;
  end

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Directed bench for switch_led_ctrl: vector table for steady-state modes plus
// hand sequences for debounce latency, glitch rejection, blink, chase and reset.
module tb_switch_led_ctrl;

  logic       Clk;
  logic       Reset;
  logic [3:0] SlideSwitch;
  logic [1:0] Mode;
  logic [7:0] LEDOut;

  int n_checks;
  int n_errors;
  int tb_presc;

  switch_led_ctrl #(
    .N_SW(4),
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .SlideSwitch(SlideSwitch),
    .Mode(Mode),
    .LEDOut(LEDOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference prescaler count, used only to align stimulus with tick edges
  always @(posedge Clk) begin
    if (Reset) tb_presc <= 0;
    else tb_presc <= (tb_presc == 7) ? 0 : tb_presc + 1;
  end

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [3:0] sw;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    n_checks++;
    if (LEDOut !== exp) begin
      n_errors++;
      $display("FAIL %s: LEDOut=%h expected=%h at %0t", name, LEDOut, exp, $time);
    end
  endtask

  task automatic align_tick;
    int guard;
    guard = 0;
    while (tb_presc != 0 && guard < 16) begin
      step(1);
      guard++;
    end
    n_checks++;
    if (tb_presc != 0) begin
      n_errors++;
      $display("FAIL align: prescaler model=%0d expected=0", tb_presc);
    end
  endtask

  initial begin
    logic [7:0] seen;
    logic [7:0] exp_b;
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{"mir_1010",   2'd0, 4'b1010, 8'h5A};
    vecs[1] = '{"dir_1011",   2'd1, 4'b1011, 8'h0B};
    vecs[2] = '{"mir_1011",   2'd0, 4'b1011, 8'hDB};
    vecs[3] = '{"dir_0110",   2'd1, 4'b0110, 8'h06};
    vecs[4] = '{"mir_0110",   2'd0, 4'b0110, 8'h66};
    vecs[5] = '{"mir_1111",   2'd0, 4'b1111, 8'hFF};
    vecs[6] = '{"dir_1000",   2'd1, 4'b1000, 8'h08};
    vecs[7] = '{"mir_1000",   2'd0, 4'b1000, 8'h18};
    vecs[8] = '{"mir_0000",   2'd0, 4'b0000, 8'h00};

    Reset = 1'b1;
    SlideSwitch = 4'b0000;
    Mode = 2'd0;
    step(2);
    check("reset_led", 8'h00);

    // Debounce latency: change first sampled at edge 0, LED at edge 6
    Reset = 1'b0;
    SlideSwitch = 4'b0001;
    for (int e = 0; e <= 5; e++) begin
      step(1);
      if (e == 0 || e == 5) check("latency_pre", 8'h00);
    end
    step(1);
    check("latency_edge6", 8'h81);

    for (int v = 0; v < 9; v++) begin
      Mode = vecs[v].mode;
      SlideSwitch = vecs[v].sw;
      step(8);
      check(vecs[v].name, vecs[v].exp);
    end

    // Short glitch is rejected
    SlideSwitch = 4'b0010;
    step(3);
    SlideSwitch = 4'b0000;
    seen = 8'h00;
    for (int e = 0; e < 10; e++) begin
      step(1);
      seen = seen | LEDOut;
    end
    check("glitch3_rejected", seen);
    check("glitch3_final", 8'h00);
    n_checks++;
    if (seen !== 8'h00) begin
      n_errors++;
      $display("FAIL glitch3_any: ored LEDOut=%h expected=00", seen);
    end

    // Six-cycle pulse is accepted, then released
    SlideSwitch = 4'b0010;
    step(6);
    SlideSwitch = 4'b0000;
    step(1);
    check("glitch6_accept", 8'h42);
    step(5);
    check("glitch6_hold", 8'h42);
    step(1);
    check("glitch6_release", 8'h00);

    // Direct to mirror takes effect one edge later
    Mode = 2'd1;
    SlideSwitch = 4'b1011;
    step(8);
    check("direct_b", 8'h0B);
    Mode = 2'd0;
    step(1);
    check("mode_switch_mirror", 8'hDB);

    // Blink
    SlideSwitch = 4'b0011;
    step(8);
    check("blink_pre_mirror", 8'hC3);
    Mode = 2'd1;
    step(1);
    align_tick();
    Mode = 2'd2;
    step(1);
    check("blink_entry", 8'hC3);
    step(7);
    check("blink_e8", 8'hC3);
    step(1);
    check("blink_e9_off", 8'h00);
    step(7);
    check("blink_e16_off", 8'h00);
    step(1);
    check("blink_e17_on", 8'hC3);
    step(8);
    check("blink_e25_off", 8'h00);

    // Chase left with db[0]=0
    Mode = 2'd0;
    SlideSwitch = 4'b0000;
    step(8);
    align_tick();
    Mode = 2'd3;
    step(1);
    for (int k = 0; k <= 8; k++) begin
      exp_b = 8'h01;
      if (k < 8) exp_b = 8'(8'h01 << k);
      check($sformatf("chase_left_%0d", k), exp_b);
      if (k < 8) step(8);
    end

    // Reverse: 01 wraps to 80
    SlideSwitch = 4'b0001;
    step(7);
    check("chase_pre_rev", 8'h01);
    step(1);
    check("chase_wrap_80", 8'h80);
    step(8);
    check("chase_rev_40", 8'h40);
    step(8);
    check("chase_rev_20", 8'h20);
    step(8);
    check("chase_rev_10", 8'h10);

    // Reset mid-chase and mid-debounce
    SlideSwitch = 4'b0110;
    step(2);
    Reset = 1'b1;
    step(1);
    check("reset_mid_chase", 8'h00);
    Reset = 1'b0;
    step(1);
    check("chase_after_reset", 8'h01);
    Mode = 2'd1;
    step(1);
    check("db_cleared", 8'h00);
    step(5);
    check("db_after_reset", 8'h06);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
